// File: rtl/mem_burst_port_pkg.sv
// Shared types and helpers for the byte-serial memory burst port.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  function automatic int nbytes(input int data_width);
    return data_width / 8;
  endfunction

  // Byte index width; a single-byte word still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_burst_port_if.sv
// Request, response and 8-bit memory signals of the burst port.
interface mem_burst_port_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  Start;
  logic                  Op;
  logic [ADDR_WIDTH-1:0] BaseAddr;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] RdData;
  logic [ADDR_WIDTH-1:0] NextAddr;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [7:0]            Mem_Data;
  logic                  Mem_WR;
  logic                  Mem_CS;
  logic [7:0]            Mem_Q;

  modport slave (
    input  Start, Op, BaseAddr, WrData, Mem_Q,
    output Busy, Done, RdData, NextAddr, Mem_Address, Mem_Data, Mem_WR, Mem_CS
  );

  modport master (
    output Start, Op, BaseAddr, WrData, Mem_Q,
    input  Busy, Done, RdData, NextAddr, Mem_Address, Mem_Data, Mem_WR, Mem_CS
  );

endinterface

// File: rtl/mem_burst_port_byte_lane_select.sv
// Maps byte index k to its word lane: store byte extract and load-capture lane mask.
module byte_lane_select
  import mem_burst_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int BIG_ENDIAN = 0,
  localparam int NBYTES     = nbytes(DATA_WIDTH),
  localparam int KW         = idx_width(NBYTES)
) (
  input  logic [KW-1:0]         k,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [7:0]            store_byte,
  output logic [DATA_WIDTH-1:0] lane_mask
);

  logic [KW-1:0] lane;

  assign lane = (BIG_ENDIAN != 0) ? KW'(NBYTES - 1) - k : k;

  always_comb begin
    store_byte = '0;
    lane_mask  = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane == KW'(i)) begin
        store_byte          = data[8*i +: 8];
        lane_mask[8*i +: 8] = '1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_port.sv
// Moves one word to/from 8-bit memory as NBYTES byte accesses; Done NBYTES+1 cycles after Start.
// Start is only accepted in IDLE or DONE; Start during a burst is dropped, not queued.
module mem_burst_port
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int BIG_ENDIAN = 0
) (
  input logic             Clock,
  input logic             Reset,
  mem_burst_port_if.slave bus
);

  localparam int            NBYTES = nbytes(DATA_WIDTH);
  localparam int            KW     = idx_width(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  state_t                state, state_nxt;
  logic                  accept;
  logic                  last;
  logic [KW-1:0]         k;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] next_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] shadow_nxt;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [7:0]            store_byte;
  logic                  busy;
  logic                  done;
  logic                  mem_cs;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_dat;

  byte_lane_select #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .k         (k),
    .data      (wdata_q),
    .store_byte(store_byte),
    .lane_mask (lane_mask)
  );

  assign last = (k == K_LAST);

  // The last byte is merged here so RdData can load the full word on the edge entering DONE.
  assign shadow_nxt = (shadow & ~lane_mask) | ({NBYTES{bus.Mem_Q}} & lane_mask);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_cs    = 1'b1;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_dat   = '0;
    case (state)
      IDLE: accept = bus.Start;
      XFER: begin
        busy     = 1'b1;
        mem_cs   = 1'b0;
        mem_addr = base_q + ADDR_WIDTH'(k);
        if (op_q == OP_STORE) begin
          mem_wr  = 1'b1;
          mem_dat = store_byte;
        end
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = bus.Start;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = XFER;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      k       <= '0;
      op_q    <= OP_LOAD;
      base_q  <= '0;
      wdata_q <= '0;
      shadow  <= '0;
      rd_q    <= '0;
      next_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= bus.Op;
        base_q  <= bus.BaseAddr;
        wdata_q <= bus.WrData;
        k       <= '0;
      end else if (state == XFER) begin
        k <= last ? '0 : k + 1'b1;
      end
      if (state == XFER && op_q == OP_LOAD) shadow <= shadow_nxt;
      if (state == XFER && last) begin
        next_q <= base_q + ADDR_WIDTH'(NBYTES);
        if (op_q == OP_LOAD) rd_q <= shadow_nxt;
      end
    end
  end

  assign bus.Busy        = busy;
  assign bus.Done        = done;
  assign bus.RdData      = rd_q;
  assign bus.NextAddr    = next_q;
  assign bus.Mem_Address = mem_addr;
  assign bus.Mem_Data    = mem_dat;
  assign bus.Mem_WR      = mem_wr;
  assign bus.Mem_CS      = mem_cs;

endmodule

// File: tb/tb_mem_burst_port.sv
// Three port configurations (16-bit LE, 32-bit BE, 8-bit) against a scoreboard of expected accesses and completions.
module tb_mem_burst_port;
  import mem_burst_pkg::*;

  localparam int NB [3] = '{2, 4, 1};
  localparam int BE [3] = '{0, 1, 0};

  typedef struct {
    int          d;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  dat;
    int          cyc;
  } acc_t;

  typedef struct {
    int          d;
    logic [31:0] rd;
    logic [15:0] na;
    int          cyc;
  } done_t;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  acc_t  acc_q[$];
  done_t done_q[$];
  acc_t  mon_a;
  done_t mon_e;
  logic [31:0] model_rd [3];
  logic [31:0] cur_rd [3];

  logic        start [3];
  logic        op [3];
  logic [15:0] base [3];
  logic [31:0] wd [3];
  logic        busy [3];
  logic        dn [3];
  logic [31:0] rd [3];
  logic [15:0] na [3];
  logic [15:0] maddr [3];
  logic [7:0]  mdata [3];
  logic        mwr [3];
  logic        mcs [3];

  logic [7:0] mem0 [65536];
  logic [7:0] mem1 [65536];
  logic [7:0] mem2 [65536];

  mem_burst_port_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) i0 ();
  mem_burst_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) i1 ();
  mem_burst_port_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(16)) i2 ();

  mem_burst_port #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BIG_ENDIAN(0)) u0 (.Clock(Clock), .Reset(Reset), .bus(i0));
  mem_burst_port #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BIG_ENDIAN(1)) u1 (.Clock(Clock), .Reset(Reset), .bus(i1));
  mem_burst_port #(.DATA_WIDTH(8),  .ADDR_WIDTH(16), .BIG_ENDIAN(0)) u2 (.Clock(Clock), .Reset(Reset), .bus(i2));

  assign i0.Start = start[0];  assign i0.Op = op[0];  assign i0.BaseAddr = base[0];  assign i0.WrData = wd[0][15:0];
  assign i1.Start = start[1];  assign i1.Op = op[1];  assign i1.BaseAddr = base[1];  assign i1.WrData = wd[1];
  assign i2.Start = start[2];  assign i2.Op = op[2];  assign i2.BaseAddr = base[2];  assign i2.WrData = wd[2][7:0];

  assign i0.Mem_Q = mem0[i0.Mem_Address];
  assign i1.Mem_Q = mem1[i1.Mem_Address];
  assign i2.Mem_Q = mem2[i2.Mem_Address];

  always @(posedge Clock) if (!i0.Mem_CS && i0.Mem_WR) mem0[i0.Mem_Address] <= i0.Mem_Data;
  always @(posedge Clock) if (!i1.Mem_CS && i1.Mem_WR) mem1[i1.Mem_Address] <= i1.Mem_Data;
  always @(posedge Clock) if (!i2.Mem_CS && i2.Mem_WR) mem2[i2.Mem_Address] <= i2.Mem_Data;

  assign busy[0] = i0.Busy;  assign dn[0] = i0.Done;  assign rd[0] = 32'(i0.RdData);  assign na[0] = i0.NextAddr;
  assign busy[1] = i1.Busy;  assign dn[1] = i1.Done;  assign rd[1] = i1.RdData;       assign na[1] = i1.NextAddr;
  assign busy[2] = i2.Busy;  assign dn[2] = i2.Done;  assign rd[2] = 32'(i2.RdData);  assign na[2] = i2.NextAddr;
  assign maddr[0] = i0.Mem_Address;  assign mdata[0] = i0.Mem_Data;  assign mwr[0] = i0.Mem_WR;  assign mcs[0] = i0.Mem_CS;
  assign maddr[1] = i1.Mem_Address;  assign mdata[1] = i1.Mem_Data;  assign mwr[1] = i1.Mem_WR;  assign mcs[1] = i1.Mem_CS;
  assign maddr[2] = i2.Mem_Address;  assign mdata[2] = i2.Mem_Data;  assign mwr[2] = i2.Mem_WR;  assign mcs[2] = i2.Mem_CS;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected accesses and completion for a burst whose Start is sampled on the next edge.
  task automatic push(input int d, input logic o, input logic [15:0] b, input logic [31:0] w,
                      input logic [31:0] load_exp);
    int    c0;
    acc_t  a;
    done_t e;
    c0 = cyc + 1;
    for (int k = 0; k < NB[d]; k++) begin
      int l;
      l      = (BE[d] != 0) ? NB[d] - 1 - k : k;
      a.d    = d;
      a.addr = b + 16'(k);
      a.wr   = o;
      a.dat  = (o == OP_STORE) ? w[8*l +: 8] : 8'h00;
      a.cyc  = c0 + k;
      acc_q.push_back(a);
    end
    if (o == OP_LOAD) model_rd[d] = load_exp;
    e.d   = d;
    e.rd  = model_rd[d];
    e.na  = b + 16'(NB[d]);
    e.cyc = c0 + NB[d];
    done_q.push_back(e);
  endtask

  task automatic burst(input int d, input logic o, input logic [15:0] b, input logic [31:0] w,
                       input logic [31:0] load_exp);
    push(d, o, b, w, load_exp);
    start[d] = 1'b1;
    op[d]    = o;
    base[d]  = b;
    wd[d]    = w;
    @(negedge Clock);
    start[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (acc_q.size() != 0 || done_q.size() != 0); i++) @(negedge Clock);
    chk("drain_timeout", 32'(acc_q.size() + done_q.size()), 32'd0);
    @(negedge Clock);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
      chk({tag, "_done"}, 32'(dn[d]), 32'd0);
      chk({tag, "_rd"},   rd[d], 32'd0);
      chk({tag, "_na"},   32'(na[d]), 32'd0);
      chk({tag, "_cs"},   32'(mcs[d]), 32'd1);
      chk({tag, "_wr"},   32'(mwr[d]), 32'd0);
      chk({tag, "_addr"}, 32'(maddr[d]), 32'd0);
      chk({tag, "_data"}, 32'(mdata[d]), 32'd0);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      for (int d = 0; d < 3; d++) begin
        if (busy[d] || !mcs[d]) begin
          chk("busy_vs_cs", 32'(busy[d]), 32'(!mcs[d]));
          chk("rd_hold", rd[d], cur_rd[d]);
          if (acc_q.size() == 0 || acc_q[0].d != d) begin
            chk("spurious_access", 32'(mcs[d]), 32'd1);
          end else begin
            mon_a = acc_q.pop_front();
            chk("acc_addr", 32'(maddr[d]), 32'(mon_a.addr));
            chk("acc_wr",   32'(mwr[d]),   32'(mon_a.wr));
            chk("acc_data", 32'(mdata[d]), 32'(mon_a.dat));
            chk("acc_cyc",  32'(cyc),      32'(mon_a.cyc));
          end
        end
        if (dn[d]) begin
          if (done_q.size() == 0 || done_q[0].d != d) begin
            chk("spurious_done", 32'(dn[d]), 32'd0);
          end else begin
            mon_e = done_q.pop_front();
            chk("rd_data",   rd[d],         mon_e.rd);
            chk("next_addr", 32'(na[d]),    32'(mon_e.na));
            chk("done_cyc",  32'(cyc),      32'(mon_e.cyc));
            chk("done_cs",   32'(mcs[d]),   32'd1);
            chk("done_busy", 32'(busy[d]),  32'd0);
            cur_rd[d] = mon_e.rd;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; op[d] = OP_LOAD; base[d] = '0; wd[d] = '0;
      model_rd[d] = '0; cur_rd[d] = '0;
    end
    repeat (3) @(negedge Clock);
    check_reset_state("rst");
    Reset = 1'b1;
    @(negedge Clock);

    // 16-bit little-endian store, read-back and address wrap
    burst(0, OP_STORE, 16'h0040, 32'h0000BEEF, 32'h0);
    drain();
    chk("mem0_0040", 32'(mem0[16'h0040]), 32'hEF);
    chk("mem0_0041", 32'(mem0[16'h0041]), 32'hBE);
    burst(0, OP_LOAD, 16'h0040, 32'h0, 32'h0000BEEF);
    drain();
    burst(0, OP_STORE, 16'hFFFF, 32'h00005AA5, 32'h0);
    drain();
    chk("mem0_ffff", 32'(mem0[16'hFFFF]), 32'hA5);
    chk("mem0_0000", 32'(mem0[16'h0000]), 32'h5A);
    burst(0, OP_LOAD, 16'hFFFF, 32'h0, 32'h00005AA5);
    drain();

    // 32-bit big-endian
    burst(1, OP_STORE, 16'h0010, 32'h12345678, 32'h0);
    drain();
    chk("mem1_0010", 32'(mem1[16'h0010]), 32'h12);
    chk("mem1_0013", 32'(mem1[16'h0013]), 32'h78);
    burst(1, OP_LOAD, 16'h0010, 32'h0, 32'h12345678);
    drain();
    burst(1, OP_STORE, 16'h0200, 32'hCAFEF00D, 32'h0);
    drain();
    burst(1, OP_LOAD, 16'h0200, 32'h0, 32'hCAFEF00D);
    drain();

    // 8-bit: single-cycle XFER
    burst(2, OP_STORE, 16'h0077, 32'h000000A5, 32'h0);
    drain();
    burst(2, OP_LOAD, 16'h0077, 32'h0, 32'h000000A5);
    drain();

    // Start held high: bursts accepted on cycles 0, 3, 6 only
    for (int i = 0; i < 9; i++) begin
      start[0] = 1'b1; op[0] = OP_STORE; base[0] = 16'h0100; wd[0] = 32'h00001234;
      if (i % 3 == 0) push(0, OP_STORE, 16'h0100, 32'h00001234, 32'h0);
      @(negedge Clock);
    end
    start[0] = 1'b0;
    drain();

    // Reset in the second XFER cycle of a 32-bit load
    burst(1, OP_LOAD, 16'h0010, 32'h0, 32'h12345678);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_cs",   32'(mcs[1]),  32'd1);
    chk("abort_rd",   rd[1],        32'd0);
    acc_q.delete();
    done_q.delete();
    for (int d = 0; d < 3; d++) begin
      model_rd[d] = '0;
      cur_rd[d]   = '0;
    end
    @(negedge Clock);
    check_reset_state("abort");
    Reset = 1'b1;
    repeat (6) @(negedge Clock);
    burst(1, OP_LOAD, 16'h0200, 32'h0, 32'hCAFEF00D);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
